// File: rtl/data_ram_rd_arbiter.sv
// data_ram_rd_arbiter: shares the single read port of the data RAM between
// the STP (0), EVP (1) and EVB (2) instruction engines. Each accepted read
// takes an ISSUE cycle (grant + RAM read enable) and a CAPTURE cycle (data
// returned to the owner). The next winner is picked while capturing, so
// reads can follow each other every two cycles.
// Build option: define DATA_ARB_RR_EN for round-robin arbitration; without
// it the arbitration is fixed priority 0 > 1 > 2.
module data_ram_rd_arbiter #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  localparam int AW         = $clog2(buffer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_instr,
  input  logic [2:0]           req,
  input  logic [AW-1:0]        addr_0,
  input  logic [AW-1:0]        addr_1,
  input  logic [AW-1:0]        addr_2,
  output logic [2:0]           gnt,
  output logic [2:0]           rvalid,
  output logic [word_size-1:0] rdata,
  output logic                 ram_rd_en,
  output logic [AW-1:0]        ram_rd_addr,
  input  logic [word_size-1:0] ram_q,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE
  } state_t;

  state_t          r_state;
  logic [1:0]      r_win;
  logic [AW-1:0]   r_addr;
  logic [2:0]      r_gnt;
  logic [2:0]      r_rvalid;
  logic            r_rd_en;
  logic            r_busy;

  logic            w_any;
  logic [1:0]      w_sel;
  logic [AW-1:0]   w_sel_addr;
  logic            w_accept;

  assign w_any    = |req;
  // A new winner is taken only from IDLE or CAPTURE, never during ISSUE.
  assign w_accept = w_any && (r_state != S_ISSUE);

`ifdef DATA_ARB_RR_EN
  logic [1:0] r_ptr;
  logic [2:0] w_sum;
  logic [1:0] w_cand;
  logic       w_found;

  // Round-robin search starting at the pointer: p, p+1, p+2 (mod 3).
  always_comb begin
    w_sel   = '0;
    w_sum   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_sum  = {1'b0, r_ptr} + 3'(k);
      w_cand = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
      if (!w_found && req[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // Pointer moves past the winner when its read is issued; an instruction
  // flush leaves it alone so fairness survives RST commands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (rst_instr && w_accept) begin
      r_ptr <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
    end
  end
`else
  // Fixed priority: requester 0 first, then 1, then 2.
  always_comb begin
    if (req[0])      w_sel = 2'd0;
    else if (req[1]) w_sel = 2'd1;
    else             w_sel = 2'd2;
  end
`endif

  // Address of the selected requester, latched on acceptance.
  always_comb begin
    case (w_sel)
      2'd0:    w_sel_addr = addr_0;
      2'd1:    w_sel_addr = addr_1;
      default: w_sel_addr = addr_2;
    endcase
  end

  // Read FSM with registered grant, read enable, valid and busy outputs.
  always_ff @(posedge clk) begin
    if (!rst || !rst_instr) begin
      r_state  <= S_IDLE;
      r_win    <= '0;
      r_addr   <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_ISSUE: begin
          r_state  <= S_CAPTURE;
          r_gnt    <= '0;
          r_rd_en  <= 1'b0;
          r_rvalid <= 3'b001 << r_win;
          r_busy   <= 1'b1;
        end
        default: begin
          r_rvalid <= '0;
          if (w_accept) begin
            r_state <= S_ISSUE;
            r_win   <= w_sel;
            r_addr  <= w_sel_addr;
            r_gnt   <= 3'b001 << w_sel;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign rvalid      = r_rvalid;
  assign ram_rd_en   = r_rd_en;
  assign ram_rd_addr = r_addr;
  assign busy        = r_busy;
  assign rdata       = (|r_rvalid) ? ram_q : '0;

endmodule

// File: tb/tb_data_ram_rd_arbiter.sv
// Directed bench for data_ram_rd_arbiter with a synchronous-read RAM model.
// Expectations follow DATA_ARB_RR_EN when it is defined for the build.
module tb_data_ram_rd_arbiter;

`ifdef DATA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_instr;
  logic [2:0]  req;
  logic [9:0]  addr_0, addr_1, addr_2;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        ram_rd_en;
  logic [9:0]  ram_rd_addr;
  logic [15:0] ram_q;
  logic        busy;

  logic [15:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  data_ram_rd_arbiter #(.word_size(16), .buffer_size(1024)) dut (
    .clk(clk), .rst(rst), .rst_instr(rst_instr), .req(req),
    .addr_0(addr_0), .addr_1(addr_1), .addr_2(addr_2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_q(ram_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_rd_en) ram_q <= mem[ram_rd_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"},    32'(gnt),       32'h0);
    chk({tag, ".rvalid"}, 32'(rvalid),    32'h0);
    chk({tag, ".rd_en"},  32'(ram_rd_en), 32'h0);
    chk({tag, ".busy"},   32'(busy),      32'h0);
    chk({tag, ".rdata"},  32'(rdata),     32'h0);
  endtask

  logic [2:0]  exp_g [4];
  logic [15:0] exp_d [4];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 3 + 1);
    mem[0] = 16'h0A0A; mem[1] = 16'h1B1B; mem[2] = 16'h2C2C;
    mem[3] = 16'h1111; mem[4] = 16'h2222; mem[5] = 16'hBEEF;
    mem[7] = 16'h7777;

    // Reset held with all requests asserted.
    rst = 1'b0; rst_instr = 1'b1; req = 3'b111;
    addr_0 = 10'd0; addr_1 = 10'd1; addr_2 = 10'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("reset");
      chk("reset.addr", 32'(ram_rd_addr), 32'h0);
    end

    // Contention with req=111 held from reset release.
    if (RR) begin
      exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
      exp_d[0] = 16'h0A0A; exp_d[1] = 16'h1B1B; exp_d[2] = 16'h2C2C; exp_d[3] = 16'h0A0A;
    end else begin
      for (int k = 0; k < 4; k++) begin exp_g[k] = 3'b001; exp_d[k] = 16'h0A0A; end
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("cont.gnt",   32'(gnt),       32'(exp_g[k]));
      chk("cont.rd_en", 32'(ram_rd_en), 32'h1);
      if (k == 3) req = 3'b000;
      step();
      chk("cont.cap_gnt", 32'(gnt),    32'h0);
      chk("cont.rvalid",  32'(rvalid), 32'(exp_g[k]));
      chk("cont.rdata",   32'(rdata),  32'(exp_d[k]));
    end
    step();
    chk_idle("cont.end");

    // Single read by requester 1.
    req = 3'b010; addr_1 = 10'h005;
    step();
    chk("single.gnt",  32'(gnt),         32'h2);
    chk("single.addr", 32'(ram_rd_addr), 32'h5);
    chk("single.busy", 32'(busy),        32'h1);
    req = 3'b000;
    step();
    chk("single.rvalid", 32'(rvalid), 32'h2);
    chk("single.rdata",  32'(rdata),  32'hBEEF);
    chk("single.busy2",  32'(busy),   32'h1);
    step();
    chk_idle("single.end");

    // Back-to-back reads by requester 0 (addresses 3 then 4).
    req = 3'b001; addr_0 = 10'd3;
    step();
    chk("b2b.gnt1",  32'(gnt),         32'h1);
    chk("b2b.addr1", 32'(ram_rd_addr), 32'h3);
    addr_0 = 10'd4;
    step();
    chk("b2b.rvalid1", 32'(rvalid), 32'h1);
    chk("b2b.rdata1",  32'(rdata),  32'h1111);
    step();
    chk("b2b.gnt2",  32'(gnt),         32'h1);
    chk("b2b.addr2", 32'(ram_rd_addr), 32'h4);
    chk("b2b.busy",  32'(busy),        32'h1);
    req = 3'b000;
    step();
    chk("b2b.rvalid2", 32'(rvalid), 32'h1);
    chk("b2b.rdata2",  32'(rdata),  32'h2222);
    step();
    chk_idle("b2b.end");

    // Instruction flush while idle keeps the pointer (now 1 under RR).
    rst_instr = 1'b0; req = 3'b111;
    step();
    chk_idle("iflush");
    rst_instr = 1'b1;
    step();
    chk("iflush.gnt", 32'(gnt), RR ? 32'h2 : 32'h1);
    req = 3'b000;
    step();
    step();
    chk_idle("iflush.end");

    // Flush during the ISSUE cycle of a requester-2 read.
    req = 3'b100; addr_2 = 10'd7;
    step();
    chk("flush.gnt",  32'(gnt),         32'h4);
    chk("flush.addr", 32'(ram_rd_addr), 32'h7);
    rst_instr = 1'b0; req = 3'b000;
    step();
    chk_idle("flush.a");
    rst_instr = 1'b1;
    step();
    chk_idle("flush.b");
    req = 3'b111;
    step();
    chk("flush.next_gnt", 32'(gnt), 32'h1);
    step();
    chk("flush.rvalid", 32'(rvalid), 32'h1);
    step();
    chk("flush.next_gnt2", 32'(gnt), RR ? 32'h2 : 32'h1);
    req = 3'b000;
    step();
    step();
    chk_idle("flush.end");

    // Late arrival: req[1] rises during requester 0's ISSUE.
    req = 3'b001; addr_0 = 10'd3; addr_1 = 10'd5;
    step();
    chk("late.gnt0", 32'(gnt), 32'h1);
    req = 3'b010;
    step();
    chk("late.cap_gnt", 32'(gnt),    32'h0);
    chk("late.rvalid0", 32'(rvalid), 32'h1);
    chk("late.rdata0",  32'(rdata),  32'h1111);
    step();
    chk("late.gnt1", 32'(gnt),         32'h2);
    chk("late.addr", 32'(ram_rd_addr), 32'h5);
    req = 3'b000;
    step();
    chk("late.rvalid1", 32'(rvalid), 32'h2);
    chk("late.rdata1",  32'(rdata),  32'hBEEF);
    step();
    chk_idle("late.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
